// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded integer register file.
package regfile_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 2;

  localparam logic [31:0] MEM_DEPTH       = 32'h0001_0000;
  localparam logic [31:0] SP_INIT_DEFAULT = MEM_DEPTH + 32'h0100_0000;

  localparam int DEFAULT_NUM_REGS = 32;
  typedef logic [DEFAULT_NUM_REGS-1:0] busy_vec_t;

endpackage

// File: rtl/register_file_sb_popcount.sv
// Combinational population count of a W-bit vector.
module popcount #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// RISC-V integer register file with registered read ports, write-first bypass
// and a per-register pending-write scoreboard for the hazard unit.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEFAULT),
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr,
  output logic [NUM_RD_PORTS*XLEN-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]      rd_busy,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [XLEN-1:0]              wr_data,
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_addr,
  input  logic                         flush,
  output logic [AW:0]                  busy_count
);

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                wr_hit;
  logic                issue_hit;

  assign wr_hit    = wr_en    && (wr_addr    != AW'(REG_ZERO));
  assign issue_hit = issue_en && (issue_addr != AW'(REG_ZERO));

  // Flops rather than RAM: every entry must clear asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Issue is applied after writeback so a new producer wins the same edge.
  always_comb begin
    busy_next = busy;
    if (wr_hit) busy_next[wr_addr] = 1'b0;
    if (flush) busy_next = '0;
    else if (issue_hit) busy_next[issue_addr] = 1'b1;
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            bypass;
    logic [XLEN-1:0] data_q;
    logic            busy_q;

    assign addr   = rd_addr[p*AW +: AW];
    assign bypass = wr_hit && (wr_addr == addr);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= bypass ? wr_data : regs[addr];
        busy_q <= busy_next[addr];
      end
    end

    assign rd_data[p*XLEN +: XLEN] = data_q;
    assign rd_busy[p]              = busy_q;
  end

  popcount #(
    .W  (NUM_REGS),
    .CW (AW + 1)
  ) u_popcount (
    .bits  (busy),
    .count (busy_count)
  );

endmodule

// File: tb/tb_register_file_sb.sv
// Randomised and directed bench for register_file_sb against an array-based model.
module tb_register_file_sb;

  localparam int NREG = 32;
  localparam int NP   = 4;
  localparam int AW   = 5;
  localparam logic [31:0] SP   = 32'h0101_0000;
  localparam logic [63:0] S_SP = 64'h0000_0001_0000_0000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // main DUT: 32 x 32, four read ports
  logic [NP*AW-1:0] rd_addr;
  logic [NP*32-1:0] rd_data;
  logic [NP-1:0]    rd_busy;
  logic             wr_en, issue_en, flush;
  logic [AW-1:0]    wr_addr, issue_addr;
  logic [31:0]      wr_data;
  logic [AW:0]      busy_count;
  logic [AW-1:0]    ra [NP];

  // second DUT: 16 x 64, two read ports
  logic [7:0]   s_rd_addr;
  logic [127:0] s_rd_data;
  logic [1:0]   s_rd_busy;
  logic         s_wr_en, s_issue_en, s_flush;
  logic [3:0]   s_wr_addr, s_issue_addr;
  logic [63:0]  s_wr_data;
  logic [4:0]   s_busy_count;

  register_file_sb #(.XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(4), .SP_INIT(SP)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .flush(flush), .busy_count(busy_count));

  register_file_sb #(.XLEN(64), .NUM_REGS(16), .NUM_RD_PORTS(2), .SP_INIT(S_SP)) dut_s (
    .clock(clock), .reset(reset), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .issue_en(s_issue_en),
    .issue_addr(s_issue_addr), .flush(s_flush), .busy_count(s_busy_count));

  always_comb begin
    rd_addr = '0;
    for (int p = 0; p < NP; p++) rd_addr[p*AW +: AW] = ra[p];
  end

  // behavioural model of the main DUT
  logic [31:0] m_regs [NREG];
  bit          m_busy [NREG];
  logic [31:0] exp_data [NP];
  bit          exp_busy [NP];
  bit          chk_en = 1'b0;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] dd(input int p);
    return rd_data[p*32 +: 32];
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_regs[2] = SP;
    for (int p = 0; p < NP; p++) begin
      exp_data[p] = '0;
      exp_busy[p] = 1'b0;
    end
  endtask

  // Apply one edge's worth of architectural rules, then sample reads.
  task automatic model_edge();
    if (wr_en && wr_addr != 0) begin
      m_regs[wr_addr] = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else if (issue_en && issue_addr != 0) begin
      m_busy[issue_addr] = 1'b1;
    end
    for (int p = 0; p < NP; p++) begin
      exp_data[p] = m_regs[ra[p]];
      exp_busy[p] = m_busy[ra[p]];
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_issue_en = 1'b0; s_issue_addr = '0; s_flush = 1'b0;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      for (int p = 0; p < NP; p++) begin
        check($sformatf("rd_data[%0d]", p), 64'(dd(p)), 64'(exp_data[p]));
        check($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(exp_busy[p]));
      end
      check("busy_count", 64'(busy_count), 64'(m_count()));
    end
  end

  initial begin
    idle();
    for (int p = 0; p < NP; p++) ra[p] = '0;
    s_rd_addr = {4'd0, 4'd2};
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_count", 64'(busy_count), 64'd0);
    check("reset_data", 64'(rd_data[31:0]), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // SP reset value on both instances
    ra[0] = 5'd2;
    cycle();
    check("sp_init", 64'(dd(0)), 64'h0101_0000);
    check("s_sp_init", s_rd_data[63:0], 64'h0000_0001_0000_0000);

    // mid-run asynchronous reset
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    issue_en = 1'b1; issue_addr = 5'd6;
    cycle();
    idle(); ra[0] = 5'd5;
    cycle();
    check("x5_before_reset", 64'(dd(0)), 64'hDEAD_BEEF);
    check("count_before_reset", 64'(busy_count), 64'd1);
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rd_data", 64'(rd_data[63:0]), 64'd0);
    check("async_rd_busy", 64'(rd_busy), 64'd0);
    check("async_count", 64'(busy_count), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    ra[0] = 5'd2; ra[1] = 5'd5;
    cycle();
    check("post_reset_sp", 64'(dd(0)), 64'h0101_0000);
    check("post_reset_x5", 64'(dd(1)), 64'd0);
    check("post_reset_count", 64'(busy_count), 64'd0);

    // write-first bypass, and writes to x0 are dropped
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
    ra[0] = 5'd7; ra[1] = 5'd0;
    cycle();
    check("bypass_x7", 64'(dd(0)), 64'h1234_5678);
    wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    cycle();
    check("write_x0", 64'(dd(1)), 64'd0);
    idle();

    // scoreboard issue / writeback
    issue_en = 1'b1; issue_addr = 5'd3; ra[0] = 5'd3;
    cycle();
    check("issue_visible_same_edge", 64'(rd_busy[0]), 64'd1);
    idle();
    cycle();
    check("x3_busy", 64'(rd_busy[0]), 64'd1);
    check("x3_count", 64'(busy_count), 64'd1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_00A5;
    cycle();
    check("x3_data", 64'(dd(0)), 64'h0000_00A5);
    check("x3_cleared", 64'(rd_busy[0]), 64'd0);
    check("x3_count0", 64'(busy_count), 64'd0);

    // same-edge issue and write: data lands, busy stays set
    wr_addr = 5'd4; wr_data = 32'h0000_CAFE;
    issue_en = 1'b1; issue_addr = 5'd4; ra[0] = 5'd4;
    cycle();
    check("x4_data", 64'(dd(0)), 64'h0000_CAFE);
    check("x4_busy", 64'(rd_busy[0]), 64'd1);
    idle();
    issue_en = 1'b1; issue_addr = 5'd8; flush = 1'b1;
    cycle();
    check("flush_issue_count", 64'(busy_count), 64'd0);
    idle();

    // all four ports, one on x0
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0055;
    cycle();
    idle();
    ra[0] = 5'd9; ra[1] = 5'd9; ra[2] = 5'd0; ra[3] = 5'd9;
    cycle();
    check("mp_port0", 64'(dd(0)), 64'h55);
    check("mp_port1", 64'(dd(1)), 64'h55);
    check("mp_port2_x0", 64'(dd(2)), 64'h0);
    check("mp_port3", 64'(dd(3)), 64'h55);

    // randomised traffic
    for (int n = 0; n < 600; n++) begin
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_addr    = AW'($urandom_range(0, NREG-1));
      wr_data    = $urandom;
      issue_en   = ($urandom_range(0, 2) != 0);
      issue_addr = AW'($urandom_range(0, NREG-1));
      flush      = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < NP; p++) ra[p] = AW'($urandom_range(0, NREG-1));
      if ($urandom_range(0, 3) == 0) ra[0] = wr_addr;
      if ($urandom_range(0, 3) == 0) ra[1] = issue_addr;
      cycle();
    end
    idle();

    // 16 x 64 instance: fill the scoreboard
    for (int a = 1; a < 16; a++) begin
      s_issue_en = 1'b1; s_issue_addr = 4'(a);
      cycle();
    end
    check("s_count_full", 64'(s_busy_count), 64'd15);
    s_issue_addr = 4'd0;
    cycle();
    check("s_count_x0", 64'(s_busy_count), 64'd15);
    s_issue_en = 1'b0;
    s_wr_en = 1'b1; s_wr_addr = 4'd9; s_wr_data = 64'h0123_4567_89AB_CDEF;
    s_rd_addr = {4'd0, 4'd9};
    cycle();
    check("s_x9_data", s_rd_data[63:0], 64'h0123_4567_89AB_CDEF);
    check("s_x9_busy", 64'(s_rd_busy[0]), 64'd0);
    check("s_count_14", 64'(s_busy_count), 64'd14);
    idle();
    s_flush = 1'b1;
    cycle();
    check("s_flush_count", 64'(s_busy_count), 64'd0);
    idle();
    cycle();

    chk_en = 1'b0;
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
